// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer pixel writer.
//   - Default frame geometry and bus widths.
//   - fb_wr_state_t : writer FSM states.
//   - fb_pixel_t    : one buffered pixel, already converted to a linear address.
//   - fb_linear_addr: row-major address y*width + x, computed unsigned at FB_ADDR_W bits.
package fb_pkg;

  localparam int FB_WIDTH      = 640;
  localparam int FB_HEIGHT     = 480;
  localparam int FB_ADDR_W     = 19;
  localparam int FB_COLOR_W    = 3;
  localparam int FB_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } fb_wr_state_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0]  addr;
    logic [FB_COLOR_W-1:0] color;
  } fb_pixel_t;

  // The line width defaults to the standard frame but can be overridden so
  // that reduced-geometry instances share the same address arithmetic.
  function automatic logic [FB_ADDR_W-1:0] fb_linear_addr(
    input logic [9:0]  x,
    input logic [8:0]  y,
    input int unsigned width = FB_WIDTH
  );
    logic [FB_ADDR_W-1:0] w;
    w = FB_ADDR_W'(width);
    return (FB_ADDR_W'(y) * w) + FB_ADDR_W'(x);
  endfunction

endpackage

// File: rtl/fb_pixel_writer_if.sv
// Pixel stream from line_drawer to fb_pixel_writer.
// Handshake: the master holds pix_valid and the payload (pix_x, pix_y,
// pix_color) stable until it sees pix_ready; a pixel transfers on every
// rising clock edge where pix_valid && pix_ready. pix_ready never depends
// on pix_valid.
//   master : line_drawer side (drives valid + payload)
//   slave  : fb_pixel_writer side (drives ready)
interface fb_pixel_if #(
  parameter int COLOR_W = fb_pkg::FB_COLOR_W
);
  logic               pix_valid;
  logic               pix_ready;
  logic [9:0]         pix_x;
  logic [8:0]         pix_y;
  logic [COLOR_W-1:0] pix_color;

  modport master (
    output pix_valid, pix_x, pix_y, pix_color,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_color,
    output pix_ready
  );
endinterface

// File: rtl/fb_pixel_writer_fifo.sv
// pixel_fifo: synchronous FIFO of fb_pixel_t entries.
//   clk, reset_n : clock, asynchronous active-low reset (pointers only)
//   push, data_in: write data_in when not full
//   pop          : advance the head when not empty
//   flush        : discard all entries; overrides push and pop on the same edge
//   full, empty  : occupancy flags
//   head         : oldest entry (valid when !empty)
// DEPTH must be a power of two, at least 2.
module pixel_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = FB_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  fb_pixel_t data_in,
  output logic      full,
  output logic      empty,
  output fb_pixel_t head
);

  localparam int PW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  fb_pixel_t   mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage needs no reset: empty masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= data_in;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: takes (x, y, colour) pixels from line_drawer, buffers
// them, and writes one pixel per cycle into the frame-buffer RAM write port.
// On request it sweeps the whole frame with a fill colour.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   pix           : pixel stream (slave side of fb_pixel_if)
//   clear_req     : start a full-frame clear (taken in IDLE only)
//   clear_color   : fill colour, latched when the clear is taken
//   busy          : high while the sweep runs
//   clear_done    : one-cycle pulse after the last sweep write
//   fb_addr/data  : registered RAM write address/data
//   fb_wren       : registered RAM write enable
//   drop_count    : saturating count of out-of-range pixels
//   dbg_state     : current FSM state
// ADDR_W/COLOR_W must match FB_ADDR_W/FB_COLOR_W, since the buffered
// pixel record is fb_pixel_t.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int WIDTH      = FB_WIDTH,
  parameter int HEIGHT     = FB_HEIGHT,
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int COLOR_W    = FB_COLOR_W,
  parameter int FIFO_DEPTH = FB_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset_n,
  fb_pixel_if.slave          pix,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               busy,
  output logic               clear_done,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               fb_wren,
  output logic [15:0]        drop_count,
  output fb_wr_state_t       dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [9:0]        X_LIMIT   = 10'(WIDTH);
  localparam logic [8:0]        Y_LIMIT   = 9'(HEIGHT);

  fb_wr_state_t state;
  fb_wr_state_t state_nxt;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  fb_pixel_t          fifo_head;
  fb_pixel_t          fifo_in;

  logic               accept;
  logic               in_range;
  logic               clear_take;
  logic               drop_hit;

  logic [ADDR_W-1:0]  clr_cnt;
  logic [COLOR_W-1:0] clr_color;
  logic               sweep_end;   // last sweep address has been issued

  // ---------------- handshake / enqueue side ----------------
  assign pix.pix_ready = (state == IDLE) && !fifo_full;
  assign accept        = pix.pix_valid && pix.pix_ready;
  assign in_range      = (pix.pix_x < X_LIMIT) && (pix.pix_y < Y_LIMIT);
  assign clear_take    = (state == IDLE) && clear_req;

  // A pixel accepted on the same edge as a clear is swallowed by the flush.
  assign fifo_push = accept && in_range && !clear_take;
  assign drop_hit  = accept && !in_range;
  // The head is discarded, not written, when a clear is taken.
  assign fifo_pop  = (state == IDLE) && !fifo_empty && !clear_take;

  assign fifo_in.addr  = fb_linear_addr(pix.pix_x, pix.pix_y, WIDTH);
  assign fifo_in.color = pix.pix_color;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (clear_take),
    .data_in (fifo_in),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_req) state_nxt = CLEAR;
      CLEAR:   if (sweep_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state == CLEAR);
  assign clear_done = (state == DONE);
  assign dbg_state  = state;

  // ---------------- clear sweep counter ----------------
  // The counter stops on LAST_ADDR; sweep_end then gives the one extra
  // CLEAR cycle in which nothing is written before moving to DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt   <= '0;
      clr_color <= '0;
      sweep_end <= 1'b0;
    end else if (clear_take) begin
      clr_cnt   <= '0;
      clr_color <= clear_color;
      sweep_end <= 1'b0;
    end else if (state == CLEAR && !sweep_end) begin
      if (clr_cnt == LAST_ADDR) sweep_end <= 1'b1;
      else                      clr_cnt   <= clr_cnt + ADDR_W'(1);
    end
  end

  // ---------------- RAM write port registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_wren <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          fb_wren <= fifo_pop;
          if (fifo_pop) begin
            fb_addr <= fifo_head.addr;
            fb_data <= fifo_head.color;
          end
        end
        CLEAR: begin
          fb_wren <= !sweep_end;
          if (!sweep_end) begin
            fb_addr <= clr_cnt;
            fb_data <= clr_color;
          end
        end
        default: fb_wren <= 1'b0;
      endcase
    end
  end

  // ---------------- drop counter ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            drop_count <= '0;
    else if (drop_hit && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end

endmodule
